// File: rtl/vsync_timing_rx.sv
// Vertical sync timing receiver: recovers line position, measures frames, locks.
// Optional input synchroniser: define VSYNC_RX_SYNCHRONISER_EN.
module vsync_timing_rx #(
    parameter int V_VISIBLE   = 600,
    parameter int V_FRONT     = 1,
    parameter int V_SYNC      = 4,
    parameter int V_TOTAL     = 628,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       hSync,
    input  logic       vSync,
    output logic [9:0] lineCount,
    output logic       vVisible,
    output logic       frameStart,
    output logic [9:0] frameLen,
    output logic       locked,
    output logic       timingErr
);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } rxStateT;

    localparam logic [9:0]  LINE_LOAD = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  LINE_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LINE_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0]  WD_LAST   = 10'(V_TOTAL + V_SYNC - 1);
    localparam logic [10:0] LEN_GOOD  = 11'(V_TOTAL);
    localparam logic [3:0]  SW_GOOD   = 4'(V_SYNC);
    localparam logic [2:0]  LOCK_N    = 3'(LOCK_FRAMES);

    logic       hIn;
    logic       vIn;
    logic       hCur;
    logic       hPrev;
    logic       vCur;
    logic       vPrev;
    logic       hFall;
    logic       vFall;
    logic       vRise;

    logic [9:0]  lineNext;
    logic [9:0]  fl;
    logic [9:0]  flInc;
    logic [10:0] measured;
    logic [9:0]  measSat;
    logic [3:0]  sw;
    logic [3:0]  swInc;
    logic [3:0]  swLast;
    logic        goodFrame;
    logic        wdHit;

    rxStateT    state;
    rxStateT    stateNext;
    logic [2:0] goodCnt;
    logic [2:0] goodNext;
    logic [2:0] goodInc;
    logic       errNext;

`ifdef VSYNC_RX_SYNCHRONISER_EN
    logic [1:0] hMeta;
    logic [1:0] vMeta;

    // Two-flop synchronisers, idle high so reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hMeta <= 2'b11;
            vMeta <= 2'b11;
        end else begin
            hMeta <= {hMeta[0], hSync};
            vMeta <= {vMeta[0], vSync};
        end
    end

    assign hIn = hMeta[1];
    assign vIn = vMeta[1];
`else
    assign hIn = hSync;
    assign vIn = vSync;
`endif

    // Current/previous samples for edge detection, idle high.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hCur  <= 1'b1;
            hPrev <= 1'b1;
            vCur  <= 1'b1;
            vPrev <= 1'b1;
        end else begin
            hCur  <= hIn;
            hPrev <= hCur;
            vCur  <= vIn;
            vPrev <= vCur;
        end
    end

    assign hFall = hPrev & ~hCur;
    assign vFall = vPrev & ~vCur;
    assign vRise = ~vPrev & vCur;

    assign flInc    = (fl == 10'h3FF) ? fl : fl + 10'd1;
    assign measured = {1'b0, fl} + {10'd0, hFall};
    assign measSat  = measured[10] ? 10'h3FF : measured[9:0];
    assign swInc    = (sw == 4'hF) ? sw : sw + 4'd1;
    assign goodInc  = goodCnt + 3'd1;

    assign goodFrame = (measured == LEN_GOOD) && (swLast == SW_GOOD);
    assign wdHit     = hFall & ~vFall & (fl == WD_LAST);

    // Next line number: a vSync fall reloads, beating a coincident hSync fall.
    always_comb begin
        lineNext = lineCount;
        if (vFall) begin
            lineNext = LINE_LOAD;
        end else if (hFall) begin
            lineNext = (lineCount == LINE_LAST) ? 10'd0 : lineCount + 10'd1;
        end
    end

    // Frame length and sync width counters; a coincident hSync fall closes the old frame.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fl       <= 10'd0;
            frameLen <= 10'd0;
            sw       <= 4'd0;
            swLast   <= 4'd0;
        end else begin
            if (vFall) begin
                fl       <= 10'd0;
                frameLen <= measSat;
            end else if (hFall) begin
                fl <= flInc;
            end
            if (vFall) begin
                sw <= {3'd0, hFall};
            end else if (hFall && !vCur) begin
                sw <= swInc;
            end
            if (vRise) begin
                swLast <= sw;
            end
        end
    end

    // Lock state machine: next state, good-frame count and error pulse.
    always_comb begin
        stateNext = state;
        goodNext  = goodCnt;
        errNext   = 1'b0;
        case (state)
            SEARCH: begin
                if (vFall) begin
                    stateNext = CHECK;
                    goodNext  = 3'd0;
                end
            end
            CHECK: begin
                if (vFall) begin
                    if (goodFrame) begin
                        goodNext = goodInc;
                        if (goodInc >= LOCK_N) begin
                            stateNext = LOCKED;
                        end
                    end else begin
                        goodNext = 3'd0;
                        errNext  = 1'b1;
                    end
                end else if (wdHit) begin
                    stateNext = SEARCH;
                    goodNext  = 3'd0;
                    errNext   = 1'b1;
                end
            end
            LOCKED: begin
                if (vFall) begin
                    if (!goodFrame) begin
                        stateNext = CHECK;
                        goodNext  = 3'd0;
                        errNext   = 1'b1;
                    end
                end else if (wdHit) begin
                    stateNext = SEARCH;
                    goodNext  = 3'd0;
                    errNext   = 1'b1;
                end
            end
            default: begin
                stateNext = SEARCH;
                goodNext  = 3'd0;
            end
        endcase
    end

    // State register and registered outputs, all aligned to the same edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= SEARCH;
            goodCnt    <= 3'd0;
            lineCount  <= 10'd0;
            frameStart <= 1'b0;
            locked     <= 1'b0;
            timingErr  <= 1'b0;
            vVisible   <= 1'b0;
        end else begin
            state      <= stateNext;
            goodCnt    <= goodNext;
            lineCount  <= lineNext;
            frameStart <= vFall;
            locked     <= (stateNext == LOCKED);
            timingErr  <= errNext;
            vVisible   <= (stateNext == LOCKED) && (lineNext < LINE_VIS);
        end
    end

endmodule
